// File: rtl/sm83_cond_seq.sv
// sm83_cond_seq: post-M1 M-cycle sequencer for the SM83 conditional
// control-flow opcodes JR cc, JP cc, CALL cc and RET cc.
// The condition is evaluated from Z/C once, at accept, and is held in
// 'taken' until the next accept. The state advances only on mcyc_adv.
// Optional feature: define SM83_COND_UNCOND_EN to also accept the
// unconditional forms JR 18, JP C3, CALL CD and RET C9 (taken forced to 1).
module sm83_cond_seq #(
    parameter int WORD_SIZE = 8,
    parameter int STEP_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] opcode,
    input  logic                 zero,
    input  logic                 carry,
    input  logic                 mcyc_adv,
    output logic                 busy,
    output logic [STEP_W-1:0]    step,
    output logic                 taken,
    output logic                 done
);

    // The state encoding is the step code itself, so 'step' is a direct view
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_LO    = 4'd1,
        S_RD_HI    = 4'd2,
        S_INTERNAL = 4'd3,
        S_PUSH_HI  = 4'd4,
        S_PUSH_LO  = 4'd5,
        S_POP_LO   = 4'd6,
        S_POP_HI   = 4'd7,
        S_LOAD_PC  = 4'd8,
        S_ADD_REL  = 4'd9
    } step_e;

    typedef enum logic [1:0] {
        K_JR   = 2'd0,
        K_JP   = 2'd1,
        K_CALL = 2'd2,
        K_RET  = 2'd3
    } kind_e;

    // Class pattern is the opcode with the cc field (bits 4:3) cleared
    localparam logic [WORD_SIZE-1:0] CC_MASK = WORD_SIZE'(8'h18);
    localparam logic [WORD_SIZE-1:0] OP_JR   = WORD_SIZE'(8'h20);
    localparam logic [WORD_SIZE-1:0] OP_JP   = WORD_SIZE'(8'hC2);
    localparam logic [WORD_SIZE-1:0] OP_CALL = WORD_SIZE'(8'hC4);
    localparam logic [WORD_SIZE-1:0] OP_RET  = WORD_SIZE'(8'hC0);
`ifdef SM83_COND_UNCOND_EN
    localparam logic [WORD_SIZE-1:0] OP_JR_U   = WORD_SIZE'(8'h18);
    localparam logic [WORD_SIZE-1:0] OP_JP_U   = WORD_SIZE'(8'hC3);
    localparam logic [WORD_SIZE-1:0] OP_CALL_U = WORD_SIZE'(8'hCD);
    localparam logic [WORD_SIZE-1:0] OP_RET_U  = WORD_SIZE'(8'hC9);
`endif

    function automatic logic cond_met(input logic [1:0] cc, input logic z, input logic c);
        case (cc)
            2'b00:   cond_met = !z;
            2'b01:   cond_met = z;
            2'b10:   cond_met = !c;
            default: cond_met = c;
        endcase
    endfunction

    step_e  state_q, state_d;
    kind_e  kind_q, kind_d;
    logic   taken_q, taken_d;
    logic   done_q, done_d;

    logic [WORD_SIZE-1:0] cls;
    logic                 dec_ok;
    kind_e                dec_kind;
    logic                 dec_cond;
    step_e                dec_first;

    assign cls = opcode & ~CC_MASK;

    // Opcode decode: recognition, instruction kind, condition and first step
    always_comb begin
        dec_ok    = 1'b0;
        dec_kind  = K_JR;
        dec_cond  = cond_met(opcode[4:3], zero, carry);
        dec_first = S_IDLE;
        if (cls == OP_JR) begin
            dec_ok    = 1'b1;
            dec_kind  = K_JR;
            dec_first = S_RD_LO;
        end else if (cls == OP_JP) begin
            dec_ok    = 1'b1;
            dec_kind  = K_JP;
            dec_first = S_RD_LO;
        end else if (cls == OP_CALL) begin
            dec_ok    = 1'b1;
            dec_kind  = K_CALL;
            dec_first = S_RD_LO;
        end else if (cls == OP_RET) begin
            dec_ok    = 1'b1;
            dec_kind  = K_RET;
            dec_first = S_INTERNAL;
        end
`ifdef SM83_COND_UNCOND_EN
        else if (opcode == OP_JR_U) begin
            dec_ok    = 1'b1;
            dec_kind  = K_JR;
            dec_cond  = 1'b1;
            dec_first = S_RD_LO;
        end else if (opcode == OP_JP_U) begin
            dec_ok    = 1'b1;
            dec_kind  = K_JP;
            dec_cond  = 1'b1;
            dec_first = S_RD_LO;
        end else if (opcode == OP_CALL_U) begin
            dec_ok    = 1'b1;
            dec_kind  = K_CALL;
            dec_cond  = 1'b1;
            dec_first = S_RD_LO;
        end else if (opcode == OP_RET_U) begin
            // Unconditional RET has no condition-evaluation cycle
            dec_ok    = 1'b1;
            dec_kind  = K_RET;
            dec_cond  = 1'b1;
            dec_first = S_POP_LO;
        end
`endif
    end

    // Next-state: accept from IDLE, otherwise walk the sequence on mcyc_adv
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        taken_d = taken_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && dec_ok) begin
                state_d = dec_first;
                kind_d  = dec_kind;
                taken_d = dec_cond;
            end
        end else if (mcyc_adv) begin
            case (state_q)
                S_RD_LO: begin
                    if (kind_q == K_JR) state_d = taken_q ? S_ADD_REL : S_IDLE;
                    else                state_d = S_RD_HI;
                end
                S_RD_HI: begin
                    if (!taken_q)              state_d = S_IDLE;
                    else if (kind_q == K_CALL) state_d = S_INTERNAL;
                    else                       state_d = S_LOAD_PC;
                end
                S_INTERNAL: begin
                    if (kind_q == K_CALL) state_d = S_PUSH_HI;
                    else                  state_d = taken_q ? S_POP_LO : S_IDLE;
                end
                S_PUSH_HI: state_d = S_PUSH_LO;
                S_POP_LO:  state_d = S_POP_HI;
                S_POP_HI:  state_d = S_LOAD_PC;
                default:   state_d = S_IDLE;
            endcase
            // Any return to IDLE from an active step is a sequence completion
            done_d = (state_d == S_IDLE);
        end
    end

    // State, latched condition and done pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_JR;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            taken_q <= taken_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign step  = STEP_W'(state_q);
    assign taken = taken_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sm83_cond_seq.sv
// Scoreboard bench for sm83_cond_seq: the driver pushes the expected step
// list (and a done token carrying the expected taken bit) per accepted
// opcode; the monitor pops and compares on every advance and done pulse.
module tb_sm83_cond_seq;

    logic       clk = 1'b0;
    logic       reset, start, zero, carry, mcyc_adv;
    logic [7:0] opcode;
    logic       busy, taken, done;
    logic [3:0] step;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic last_taken;
    bit   model_taken;

    localparam int DONE_TOK = 16;

    sm83_cond_seq #(.WORD_SIZE(8), .STEP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .zero(zero), .carry(carry), .mcyc_adv(mcyc_adv),
        .busy(busy), .step(step), .taken(taken), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected step list from the instruction tables
    function automatic bit model_push(input logic [7:0] op, input logic z, input logic c);
        logic [7:0] o;
        logic [1:0] cc;
        bit cond;
        int lst[$];
        o  = op;
        cc = o[4:3];
        case (cc)
            2'd0: cond = !z;
            2'd1: cond = z;
            2'd2: cond = !c;
            default: cond = c;
        endcase
        lst = {};
        if (o inside {8'h20, 8'h28, 8'h30, 8'h38}) begin
            lst = cond ? '{1, 9} : '{1};
        end else if (o inside {8'hC2, 8'hCA, 8'hD2, 8'hDA}) begin
            lst = cond ? '{1, 2, 8} : '{1, 2};
        end else if (o inside {8'hC4, 8'hCC, 8'hD4, 8'hDC}) begin
            lst = cond ? '{1, 2, 3, 4, 5} : '{1, 2};
        end else if (o inside {8'hC0, 8'hC8, 8'hD0, 8'hD8}) begin
            lst = cond ? '{3, 6, 7, 8} : '{3};
        end
`ifdef SM83_COND_UNCOND_EN
        else begin
            cond = 1'b1;
            case (o)
                8'h18: lst = '{1, 9};
                8'hC3: lst = '{1, 2, 8};
                8'hCD: lst = '{1, 2, 3, 4, 5};
                8'hC9: lst = '{6, 7, 8};
                default: lst = {};
            endcase
        end
`endif
        if (lst.size() == 0) return 1'b0;
        foreach (lst[i]) exp_q.push_back(lst[i]);
        exp_q.push_back(DONE_TOK + int'(cond));
        model_taken = cond;
        return 1'b1;
    endfunction

    function automatic logic [7:0] pick_op();
        logic [7:0] tbl[20] = '{8'h20, 8'h28, 8'h30, 8'h38, 8'hC2, 8'hCA, 8'hD2, 8'hDA,
                                8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hC0, 8'hC8, 8'hD0, 8'hD8,
                                8'h18, 8'hC3, 8'hCD, 8'hC9};
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        return tbl[$urandom_range(0, 19)];
    endfunction

    // Monitor: compare each consumed step and each done pulse against the queue
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_taken", DONE_TOK + int'(taken), e);
                end
            end
            if (busy && mcyc_adv) begin
                if (exp_q.size() == 0) chk("unexpected_step", int'(step), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("step", int'(step), e);
                end
            end
        end
    end

    task automatic run_txn(input logic [7:0] op, input logic z, input logic c);
        bit ok;
        int budget;
        ok = model_push(op, z, c);
        start    = 1'b1;
        opcode   = op;
        zero     = z;
        carry    = c;
        mcyc_adv = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start    = 1'b0;
        mcyc_adv = 1'b0;
        if (!ok) begin
            chk("ign_busy", int'(busy), 0);
            chk("ign_done", int'(done), 0);
            chk("ign_taken", int'(taken), int'(last_taken));
            return;
        end
        chk("acc_busy", int'(busy), 1);
        last_taken = model_taken;
        budget = 0;
        while (busy && budget < 100) begin
            mcyc_adv = 1'($urandom_range(0, 1));
            zero     = 1'($urandom);
            carry    = 1'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            opcode   = pick_op();
            budget++;
            @(posedge clk); #1;
        end
        start    = 1'b0;
        mcyc_adv = 1'b0;
        if (budget >= 100) chk("timeout", 1, 0);
        chk("done_pulse", int'(done), 1);
    endtask

    task automatic reset_mid_seq();
        int budget;
        void'(model_push(8'hDC, 1'b0, 1'b1));
        start = 1'b1; opcode = 8'hDC; zero = 1'b0; carry = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (step != 4'd4 && budget < 20) begin
            mcyc_adv = 1'b1;
            budget++;
            @(posedge clk); #1;
        end
        mcyc_adv = 1'b0;
        chk("reach_push_hi", int'(step), 4);
        reset = 1'b1;
        #1;
        chk("rst_step", int'(step), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_taken", int'(taken), 0);
        chk("rst_done", int'(done), 0);
        exp_q.delete();
        last_taken = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mcyc_adv = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("rst_no_done", int'(done), 0);
        end
        mcyc_adv = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 8'h00;
        zero = 1'b0; carry = 1'b0; mcyc_adv = 1'b0;
        last_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_step", int'(step), 0);
        chk("reset_taken", int'(taken), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(8'h20, 1'b0, 1'b0);
        chk("jr_nz_taken", int'(taken), 1);
        run_txn(8'h20, 1'b1, 1'b0);
        chk("jr_nz_not_taken", int'(taken), 0);
        run_txn(8'hDC, 1'b0, 1'b1);
        chk("call_c_taken", int'(taken), 1);
        run_txn(8'hC8, 1'b0, 1'b0);
        chk("ret_z_not_taken", int'(taken), 0);
        run_txn(8'hC8, 1'b1, 1'b0);
        chk("ret_z_taken", int'(taken), 1);
        run_txn(8'h00, 1'b0, 1'b0);

        reset_mid_seq();

        run_txn(8'hC9, 1'b0, 1'b0);
`ifdef SM83_COND_UNCOND_EN
        chk("ret_uncond_taken", int'(taken), 1);
`else
        chk("ret_uncond_ignored", int'(busy), 0);
`endif

        repeat (300) begin
            run_txn(pick_op(), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                mcyc_adv = 1'b1;
                @(posedge clk); #1;
                mcyc_adv = 1'b0;
                chk("idle_adv_busy", int'(busy), 0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
